// File: rtl/spi_peripheral_if.sv
// rtl/spi_peripheral_if.sv - SPI pad bus plus core-side byte/status signals
//
// Purpose: bundles everything the SPI peripheral exchanges with the outside
// world except clk/rst.
//   Pad side  : sclk, cs_n, mosi (from external master), miso, miso_oe (to pads)
//   Mode      : cpol, cpha (captured by the peripheral when cs_n falls)
//   TX path   : tx_data, tx_valid (from core), tx_ready (to core)
//   RX path   : rx_data, rx_valid (to core)
//   Status    : busy, underrun (to core), clr_status (from core)
// Modports: slave = the peripheral, master = whatever drives it (core + pads).
interface spi_peripheral_if;
  logic       sclk;
  logic       cs_n;
  logic       mosi;
  logic       miso;
  logic       miso_oe;
  logic       cpol;
  logic       cpha;
  logic [7:0] tx_data;
  logic       tx_valid;
  logic       tx_ready;
  logic [7:0] rx_data;
  logic       rx_valid;
  logic       busy;
  logic       underrun;
  logic       clr_status;

  modport slave (
    input  sclk, cs_n, mosi, cpol, cpha, tx_data, tx_valid, clr_status,
    output miso, miso_oe, tx_ready, rx_data, rx_valid, busy, underrun
  );

  modport master (
    output sclk, cs_n, mosi, cpol, cpha, tx_data, tx_valid, clr_status,
    input  miso, miso_oe, tx_ready, rx_data, rx_valid, busy, underrun
  );
endinterface

// File: rtl/spi_peripheral.sv
// rtl/spi_peripheral.sv - SPI slave endpoint, all four CPOL/CPHA modes, MSB first
//
// Purpose: oversamples an external SPI bus with clk, receives bytes into
// rx_data (one-cycle rx_valid pulse) and shifts out bytes taken from a
// one-entry tx holding register (DEFAULT_TX when it is empty).
// Ports:
//   clk  - system clock, all logic on posedge
//   rst  - asynchronous active-low reset
//   bus  - spi_peripheral_if.slave (pads, mode, tx/rx byte paths, status)
// Parameters:
//   SYNC_STAGES - synchronizer depth on sclk/cs_n/mosi (>= 2)
//   DEFAULT_TX  - byte shifted out when nothing is pending at byte start
module spi_peripheral #(
  parameter int         SYNC_STAGES = 2,
  parameter logic [7:0] DEFAULT_TX  = 8'h00
) (
  input  logic             clk,
  input  logic             rst,
  spi_peripheral_if.slave  bus
);

  typedef enum logic {IDLE, ACTIVE} state_e;

  state_e state_q, state_d;

  // Synchronizers: bit 0 takes the pad, bit SYNC_STAGES-1 is the clean copy.
  logic [SYNC_STAGES-1:0] sclk_sync_q, sclk_sync_d;
  logic [SYNC_STAGES-1:0] cs_sync_q,   cs_sync_d;
  logic [SYNC_STAGES-1:0] mosi_sync_q, mosi_sync_d;
  logic                   sclk_hist_q, sclk_hist_d;
  logic                   cs_hist_q,   cs_hist_d;

  logic       cpol_q, cpol_d;
  logic       cpha_q, cpha_d;
  logic [2:0] bit_cnt_q, bit_cnt_d;
  logic [6:0] rx_shift_q, rx_shift_d;
  logic [7:0] shifter_q, shifter_d;
  logic [7:0] hold_q, hold_d;
  logic       hold_full_q, hold_full_d;
  logic [7:0] rx_data_q, rx_data_d;
  logic       rx_valid_q, rx_valid_d;
  logic       underrun_q, underrun_d;
  // No sample edge seen yet since the cs_n fall (suppresses the first
  // cpha=1 leading edge, whose bit was already loaded at selection).
  logic       first_q, first_d;
  // A byte completed and the next shift edge must reload instead of shift.
  logic       byte_done_q, byte_done_d;
  // A mid-stream reload fell back to DEFAULT_TX. In cpha=0 that reload
  // happens on the last trailing edge, so the underrun is only reported
  // once the new byte really starts (its first sample edge).
  logic       pend_unr_q, pend_unr_d;

  logic sclk_s, cs_s, mosi_s;
  logic cs_fall, cs_rise;
  logic lead_edge, trail_edge, sample_edge, shift_edge;
  logic load, set_unr, tx_accept;

  assign sclk_s = sclk_sync_q[SYNC_STAGES-1];
  assign cs_s   = cs_sync_q[SYNC_STAGES-1];
  assign mosi_s = mosi_sync_q[SYNC_STAGES-1];

  assign cs_fall    = cs_hist_q & ~cs_s;
  assign cs_rise    = ~cs_hist_q & cs_s;
  assign lead_edge  = (sclk_hist_q == cpol_q) && (sclk_s != cpol_q);
  assign trail_edge = (sclk_hist_q != cpol_q) && (sclk_s == cpol_q);
  assign sample_edge = cpha_q ? trail_edge : lead_edge;
  assign shift_edge  = cpha_q ? lead_edge  : trail_edge;

  assign tx_accept = bus.tx_valid & ~hold_full_q;

  always_comb begin
    sclk_sync_d = {sclk_sync_q[SYNC_STAGES-2:0], bus.sclk};
    cs_sync_d   = {cs_sync_q[SYNC_STAGES-2:0],   bus.cs_n};
    mosi_sync_d = {mosi_sync_q[SYNC_STAGES-2:0], bus.mosi};
    sclk_hist_d = sclk_s;
    cs_hist_d   = cs_s;
  end

  always_comb begin
    state_d     = state_q;
    cpol_d      = cpol_q;
    cpha_d      = cpha_q;
    bit_cnt_d   = bit_cnt_q;
    rx_shift_d  = rx_shift_q;
    shifter_d   = shifter_q;
    hold_d      = hold_q;
    hold_full_d = hold_full_q;
    rx_data_d   = rx_data_q;
    rx_valid_d  = 1'b0;
    underrun_d  = underrun_q;
    first_d     = first_q;
    byte_done_d = byte_done_q;
    pend_unr_d  = pend_unr_q;
    load        = 1'b0;
    set_unr     = 1'b0;

    case (state_q)
      IDLE: begin
        if (cs_fall) begin
          state_d     = ACTIVE;
          cpol_d      = bus.cpol;
          cpha_d      = bus.cpha;
          bit_cnt_d   = 3'd0;
          first_d     = 1'b1;
          byte_done_d = 1'b0;
          pend_unr_d  = 1'b0;
          load        = 1'b1;
        end
      end
      ACTIVE: begin
        if (cs_rise) begin
          state_d     = IDLE;
          bit_cnt_d   = 3'd0;
          rx_shift_d  = 7'd0;
          shifter_d   = 8'd0;
          first_d     = 1'b0;
          byte_done_d = 1'b0;
          pend_unr_d  = 1'b0;
        end else begin
          if (sample_edge) begin
            rx_shift_d = {rx_shift_q[5:0], mosi_s};
            bit_cnt_d  = bit_cnt_q + 3'd1;
            first_d    = 1'b0;
            if (pend_unr_q) begin
              set_unr    = 1'b1;
              pend_unr_d = 1'b0;
            end
            if (bit_cnt_q == 3'd7) begin
              rx_data_d   = {rx_shift_q, mosi_s};
              rx_valid_d  = 1'b1;
              byte_done_d = 1'b1;
            end
          end
          if (shift_edge) begin
            if (byte_done_q) begin
              load        = 1'b1;
              byte_done_d = 1'b0;
            end else if (!first_q) begin
              shifter_d = {shifter_q[6:0], 1'b0};
            end
          end
        end
      end
    endcase

    // Byte-load takes the holding register as it was before any accept
    // in this same cycle; an accepted byte then stays in holding.
    if (load) begin
      if (hold_full_q) begin
        shifter_d   = hold_q;
        hold_full_d = 1'b0;
      end else begin
        shifter_d = DEFAULT_TX;
        if (state_q == IDLE) begin
          set_unr = 1'b1;
        end else begin
          pend_unr_d = 1'b1;
        end
      end
    end
    if (tx_accept) begin
      hold_d      = bus.tx_data;
      hold_full_d = 1'b1;
    end

    if (bus.clr_status) begin
      underrun_d = 1'b0;
    end
    if (set_unr) begin
      underrun_d = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sclk_sync_q <= {SYNC_STAGES{bus.cpol}};
      cs_sync_q   <= {SYNC_STAGES{1'b1}};
      mosi_sync_q <= {SYNC_STAGES{1'b0}};
      sclk_hist_q <= bus.cpol;
      cs_hist_q   <= 1'b1;
      state_q     <= IDLE;
      cpol_q      <= 1'b0;
      cpha_q      <= 1'b0;
      bit_cnt_q   <= 3'd0;
      rx_shift_q  <= 7'd0;
      shifter_q   <= 8'd0;
      hold_q      <= 8'd0;
      hold_full_q <= 1'b0;
      rx_data_q   <= 8'd0;
      rx_valid_q  <= 1'b0;
      underrun_q  <= 1'b0;
      first_q     <= 1'b0;
      byte_done_q <= 1'b0;
      pend_unr_q  <= 1'b0;
    end else begin
      sclk_sync_q <= sclk_sync_d;
      cs_sync_q   <= cs_sync_d;
      mosi_sync_q <= mosi_sync_d;
      sclk_hist_q <= sclk_hist_d;
      cs_hist_q   <= cs_hist_d;
      state_q     <= state_d;
      cpol_q      <= cpol_d;
      cpha_q      <= cpha_d;
      bit_cnt_q   <= bit_cnt_d;
      rx_shift_q  <= rx_shift_d;
      shifter_q   <= shifter_d;
      hold_q      <= hold_d;
      hold_full_q <= hold_full_d;
      rx_data_q   <= rx_data_d;
      rx_valid_q  <= rx_valid_d;
      underrun_q  <= underrun_d;
      first_q     <= first_d;
      byte_done_q <= byte_done_d;
      pend_unr_q  <= pend_unr_d;
    end
  end

  assign bus.busy     = (state_q == ACTIVE);
  assign bus.miso_oe  = (state_q == ACTIVE);
  assign bus.miso     = (state_q == ACTIVE) & shifter_q[7];
  assign bus.tx_ready = ~hold_full_q;
  assign bus.rx_data  = rx_data_q;
  assign bus.rx_valid = rx_valid_q;
  assign bus.underrun = underrun_q;

endmodule

// File: tb/tb_spi_peripheral.sv
// tb/tb_spi_peripheral.sv - self-checking bench for spi_peripheral
module tb_spi_peripheral;
  localparam int         H    = 4;      // sclk half period in clk cycles (clk/8)
  localparam logic [7:0] DFLT = 8'h00;

  logic clk;
  logic rst_n;
  int   n_cmp;
  int   n_fail;

  spi_peripheral_if bus ();

  spi_peripheral #(.SYNC_STAGES(2), .DEFAULT_TX(DFLT)) dut (
    .clk (clk),
    .rst (rst_n),
    .bus (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  logic [7:0] rx_q[$];
  always @(negedge clk) begin
    if (bus.rx_valid) rx_q.push_back(bus.rx_data);
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  task automatic pulse_clr();
    bus.clr_status = 1'b1;
    @(negedge clk);
    bus.clr_status = 1'b0;
    @(negedge clk);
  endtask

  task automatic write_tx(input logic [7:0] d);
    int t;
    t = 0;
    while (!bus.tx_ready && t < 300) begin
      @(negedge clk);
      t++;
    end
    if (!bus.tx_ready) begin
      n_cmp++;
      n_fail++;
      $display("FAIL tx_ready_timeout: actual=0 expected=1");
    end
    bus.tx_data  = d;
    bus.tx_valid = 1'b1;
    @(negedge clk);
    bus.tx_valid = 1'b0;
  endtask

  // Bit-level SPI master. mo is sent MSB first from bit 31; miso bits land
  // in mi at the same positions.
  task automatic xfer(input logic pol, input logic pha, input logic [31:0] mo,
                      input int nbits, output logic [31:0] mi, output logic sel_ok);
    mi     = 32'd0;
    sel_ok = 1'b0;
    bus.cpol = pol;
    bus.cpha = pha;
    bus.sclk = pol;
    repeat (H) @(negedge clk);
    bus.cs_n = 1'b0;
    repeat (H) @(negedge clk);
    for (int i = 0; i < nbits; i++) begin
      if (!pha) begin
        bus.mosi = mo[31-i];
        repeat (H) @(negedge clk);
        mi[31-i] = bus.miso;
        if (i == 0) sel_ok = bus.busy & bus.miso_oe;
        bus.sclk = ~pol;
        repeat (H) @(negedge clk);
        bus.sclk = pol;
      end else begin
        bus.sclk = ~pol;
        bus.mosi = mo[31-i];
        repeat (H) @(negedge clk);
        mi[31-i] = bus.miso;
        if (i == 0) sel_ok = bus.busy & bus.miso_oe;
        bus.sclk = pol;
        repeat (H) @(negedge clk);
      end
    end
    repeat (H) @(negedge clk);
    bus.cs_n = 1'b1;
    bus.mosi = 1'b0;
    repeat (6) @(negedge clk);
  endtask

  typedef struct {
    logic       pol;
    logic       pha;
    logic       pre;
    logic [7:0] tx;
    logic [7:0] mo;
    logic [7:0] exp_rx;
    logic [7:0] exp_mi;
    logic       exp_unr;
  } vec_t;

  vec_t       vecs[8];
  logic [31:0] mi;
  logic        sel;
  logic [7:0]  hold_m[$];
  logic        pol, pha, pre;
  int          nb;
  logic [31:0] mo;
  logic [7:0]  txb, exp_b;
  logic        exp_unr;

  initial begin
    n_cmp = 0;
    n_fail = 0;
    bus.sclk = 1'b0; bus.cs_n = 1'b1; bus.mosi = 1'b0;
    bus.cpol = 1'b0; bus.cpha = 1'b0;
    bus.tx_data = 8'd0; bus.tx_valid = 1'b0; bus.clr_status = 1'b0;
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_miso", bus.miso, 0);
    check("rst_miso_oe", bus.miso_oe, 0);
    check("rst_tx_ready", bus.tx_ready, 1);
    check("rst_rx_data", bus.rx_data, 0);
    check("rst_rx_valid", bus.rx_valid, 0);
    check("rst_busy", bus.busy, 0);
    check("rst_underrun", bus.underrun, 0);
    rst_n = 1'b1;
    repeat (4) @(negedge clk);

    // Single-byte table: mode, optional preload, expected both directions.
    vecs[0] = '{1'b0, 1'b0, 1'b1, 8'hA5, 8'h3C, 8'h3C, 8'hA5, 1'b0};
    vecs[1] = '{1'b0, 1'b0, 1'b1, 8'h96, 8'h96, 8'h96, 8'h96, 1'b0};
    vecs[2] = '{1'b0, 1'b1, 1'b1, 8'h96, 8'h96, 8'h96, 8'h96, 1'b0};
    vecs[3] = '{1'b1, 1'b0, 1'b1, 8'h96, 8'h96, 8'h96, 8'h96, 1'b0};
    vecs[4] = '{1'b1, 1'b1, 1'b1, 8'h96, 8'h96, 8'h96, 8'h96, 1'b0};
    vecs[5] = '{1'b1, 1'b0, 1'b0, 8'h00, 8'h5B, 8'h5B, DFLT,  1'b1};
    vecs[6] = '{1'b0, 1'b1, 1'b1, 8'hFF, 8'h00, 8'h00, 8'hFF, 1'b0};
    vecs[7] = '{1'b1, 1'b1, 1'b1, 8'h01, 8'h80, 8'h80, 8'h01, 1'b0};

    for (int i = 0; i < 8; i++) begin
      pulse_clr();
      rx_q.delete();
      if (vecs[i].pre) begin
        write_tx(vecs[i].tx);
        check($sformatf("vec%0d_tx_ready_full", i), bus.tx_ready, 0);
      end
      xfer(vecs[i].pol, vecs[i].pha, {vecs[i].mo, 24'd0}, 8, mi, sel);
      check($sformatf("vec%0d_selected", i), sel, 1);
      check($sformatf("vec%0d_rx_count", i), rx_q.size(), 1);
      if (rx_q.size() > 0) check($sformatf("vec%0d_rx_data", i), rx_q[0], vecs[i].exp_rx);
      check($sformatf("vec%0d_miso_byte", i), mi[31:24], vecs[i].exp_mi);
      check($sformatf("vec%0d_underrun", i), bus.underrun, vecs[i].exp_unr);
      check($sformatf("vec%0d_tx_ready", i), bus.tx_ready, 1);
      check($sformatf("vec%0d_idle_miso", i), bus.miso, 0);
      check($sformatf("vec%0d_idle_oe", i), bus.miso_oe, 0);
      check($sformatf("vec%0d_idle_busy", i), bus.busy, 0);
    end

    // Back-to-back bytes, no preload, tx byte written during byte 1.
    pulse_clr();
    rx_q.delete();
    fork
      xfer(1'b0, 1'b0, {8'h11, 8'h22, 16'd0}, 16, mi, sel);
      begin
        repeat (30) @(negedge clk);
        write_tx(8'h5A);
      end
    join
    check("b2b_rx_count", rx_q.size(), 2);
    if (rx_q.size() == 2) begin
      check("b2b_rx0", rx_q[0], 8'h11);
      check("b2b_rx1", rx_q[1], 8'h22);
    end
    check("b2b_miso0", mi[31:24], 8'h00);
    check("b2b_miso1", mi[23:16], 8'h5A);
    check("b2b_underrun", bus.underrun, 1);
    pulse_clr();
    check("b2b_clr", bus.underrun, 0);

    // Abort after 5 bits; a byte written mid-abort survives to the next transfer.
    rx_q.delete();
    fork
      xfer(1'b0, 1'b0, 32'hFF00_0000, 5, mi, sel);
      begin
        repeat (12) @(negedge clk);
        write_tx(8'hE7);
      end
    join
    check("abort_no_rx", rx_q.size(), 0);
    check("abort_busy", bus.busy, 0);
    check("abort_hold_kept", bus.tx_ready, 0);
    xfer(1'b0, 1'b0, {8'h81, 24'd0}, 8, mi, sel);
    check("abort_next_count", rx_q.size(), 1);
    if (rx_q.size() > 0) check("abort_next_rx", rx_q[0], 8'h81);
    check("abort_next_miso", mi[31:24], 8'hE7);

    // Asynchronous reset mid-byte with holding full and underrun set.
    fork
      xfer(1'b0, 1'b0, {8'hC3, 24'd0}, 8, mi, sel);
      begin
        repeat (10) @(negedge clk);
        write_tx(8'h77);
        repeat (20) @(negedge clk);
        check("pre_rst_busy", bus.busy, 1);
        #2 rst_n = 1'b0;
        #1;
        check("arst_miso", bus.miso, 0);
        check("arst_miso_oe", bus.miso_oe, 0);
        check("arst_busy", bus.busy, 0);
        check("arst_tx_ready", bus.tx_ready, 1);
        check("arst_rx_data", bus.rx_data, 0);
        check("arst_rx_valid", bus.rx_valid, 0);
        check("arst_underrun", bus.underrun, 0);
      end
    join
    @(negedge clk);
    rst_n = 1'b1;
    repeat (4) @(negedge clk);
    rx_q.delete();
    xfer(1'b0, 1'b0, {8'h42, 24'd0}, 8, mi, sel);
    check("post_rst_count", rx_q.size(), 1);
    if (rx_q.size() > 0) check("post_rst_rx", rx_q[0], 8'h42);
    check("post_rst_miso", mi[31:24], DFLT);

    // clr_status in the same cycle an underrun is set at selection.
    bus.cpol = 1'b0; bus.cpha = 1'b0; bus.sclk = 1'b0;
    pulse_clr();
    check("race_pre", bus.underrun, 0);
    bus.cs_n = 1'b0;
    repeat (2) @(negedge clk);
    bus.clr_status = 1'b1;
    @(negedge clk);
    bus.clr_status = 1'b0;
    check("race_set_wins", bus.underrun, 1);
    pulse_clr();
    check("race_clr_alone", bus.underrun, 0);
    bus.cs_n = 1'b1;
    repeat (6) @(negedge clk);

    // Randomized transfers against a byte-level model of the holding register.
    hold_m.delete();
    for (int it = 0; it < 12; it++) begin
      pol = 1'($urandom_range(0, 1));
      pha = 1'($urandom_range(0, 1));
      pre = 1'($urandom_range(0, 1));
      nb  = $urandom_range(1, 3);
      mo  = $urandom;
      txb = 8'($urandom);
      pulse_clr();
      rx_q.delete();
      if (pre) begin
        write_tx(txb);
        hold_m.push_back(txb);
      end
      xfer(pol, pha, mo, nb * 8, mi, sel);
      exp_unr = 1'b0;
      check($sformatf("rnd%0d_rx_count", it), rx_q.size(), nb);
      for (int b = 0; b < nb; b++) begin
        if (hold_m.size() > 0) exp_b = hold_m.pop_front();
        else begin
          exp_b = DFLT;
          exp_unr = 1'b1;
        end
        check($sformatf("rnd%0d_miso%0d", it, b), mi[31-8*b -: 8], exp_b);
        if (rx_q.size() > b) check($sformatf("rnd%0d_rx%0d", it, b), rx_q[b], mo[31-8*b -: 8]);
      end
      check($sformatf("rnd%0d_underrun", it), bus.underrun, exp_unr);
      check($sformatf("rnd%0d_tx_ready", it), bus.tx_ready, 1);
      check($sformatf("rnd%0d_idle_oe", it), bus.miso_oe, 0);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end
endmodule
